viterbi_frame_sequencer: RTL and testbench
==========================================

# viterbi_frame_sequencer

Synthesizable frame sequencer that feeds the Viterbi decoder. It accepts softbit words on a valid/ready stream and writes them into the input SRAM. It then fires the core's frame start and waits for frame done, repeating for a programmed number of frames. Optional ping-pong banking lets frame n+1 load while the core decodes frame n; a timeout watchdog aborts a hung core.

## Interface
- SOFT_W, 24, softbit word width (input SRAM data width)
- SRC_ADDR_W, 12, input SRAM address width
- LEN_W, 12, words-per-frame counter width
- NFRM_W, 8, frame-count width
- TMO_W, 16, watchdog counter width
- clk_i  in  1  single clock, all logic rising-edge
- rst_sync_i  in  1  reset, synchronous, active-high
- start_i  in  1  run request pulse; ignored while busy_o=1
- frame_count_i  in  NFRM_W  frames per run; 0 = run ends immediately with done_o
- frame_words_i  in  LEN_W  words per frame; 0 treated as 1
- src_base_i  in  SRC_ADDR_W  bank 0 base address
- bank_stride_i  in  SRC_ADDR_W  bank 1 offset from src_base_i
- pingpong_i  in  1  1 = two banks with overlapped load; 0 = bank 0 only
- gap_cycles_i  in  8  idle cycles between bank full and frame start
- timeout_i  in  TMO_W  max WAIT cycles; 0 disables the watchdog
- s_valid_i / s_data_i / s_ready_o  in/in/out  1/SOFT_W/1  softbit stream; a beat is accepted when valid&ready
- buf_wr_o / buf_addr_o / buf_wdata_o  out  1/SRC_ADDR_W/SOFT_W  input SRAM write port
- core_frame_start_o  out  1  one-cycle pulse to the decoder
- core_src_addr_o  out  SRC_ADDR_W  bank address for the decoder; held from start until done
- core_frame_done_i  in  1  decoder completion pulse
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at run end (normal or abort)
- frames_done_o  out  NFRM_W  frames completed in the current run
- timeout_err_o  out  1  sticky abort flag; cleared by an accepted start_i

## Operation
- Configuration inputs are sampled on an accepted start_i and held internally for the run.
- Bank address: bank b → src_base + (b ? bank_stride : 0), computed mod 2^SRC_ADDR_W. Word addresses wrap the same way.
- Loader: write bank wb, word index wi.
  - s_ready_o = busy & !full[wb] & (frames_loaded < frame_count).
  - Each accepted beat writes address addr(wb)+wi.
  - On the last word (wi = frame_words-1), full[wb] is set and wi clears. If pingpong, wb toggles.
  - frames_loaded increments on the last word.
- Controller FSM, read bank rb:
  - C_IDLE: an accepted start_i clears counters, full[], wb, rb, and timeout_err_o, then goes to C_ARM. If frame_count=0, pulse done_o instead and stay in C_IDLE.
  - C_ARM: when full[rb], load the gap counter and go to C_GAP.
  - C_GAP: count gap_cycles down to 0 (0 means one pass-through cycle), then go to C_START.
  - C_START: pulse core_frame_start_o, latch core_src_addr_o = addr(rb), clear the watchdog, go to C_WAIT.
  - C_WAIT: on core_frame_done_i, clear full[rb], toggle rb if pingpong, and increment frames_done. If frames_done+1 = frame_count, pulse done_o and go to C_IDLE; otherwise go to C_ARM.
  - C_WAIT watchdog: if timeout_i≠0 and the watchdog reaches timeout_i, set timeout_err_o, pulse done_o, clear full[], and go to C_IDLE. Stream beats already in flight are dropped.
- Non-pingpong mode: the loader stalls while bank 0 is full, so load and decode strictly alternate.
- Simultaneous events: the loader setting full[wb] and the controller clearing full[rb] in the same cycle are always on different banks; both updates apply.
- core_frame_done_i outside C_WAIT is ignored.
- Reset mid-operation returns all state to reset values. The SRAM contents are left untouched.

## Timing
- Reset values: s_ready_o=0, buf_wr_o=0, buf_addr_o=0, buf_wdata_o=0, core_frame_start_o=0, core_src_addr_o=0, busy_o=0, done_o=0, frames_done_o=0, timeout_err_o=0; FSM in C_IDLE.
- busy_o rises the cycle after the accepted start_i and falls in the same cycle as done_o.
- Beat accepted at cycle t → buf_wr_o/addr/wdata registered at t+1.
- Last beat at t → full set at t+1 → C_ARM sees it at t+1 → C_GAP at t+2. With gap=0, core_frame_start_o asserts at t+3.
- core_frame_done_i at t → frames_done_o updated at t+1. done_o at t+1 when that is the final frame.
- The watchdog counts every cycle in C_WAIT. Abort occurs on the cycle the count reaches timeout_i.

## Test plan
- Single frame: frame_count=1, frame_words=0x98, base 0, gap 0, pingpong 0, stream always valid → 152 writes to addresses 0..0x97 with data in order. core_frame_start_o fires 3 cycles after the last beat with core_src_addr_o=0. Done returned 50 cycles later → done_o and frames_done_o=1.
- Ping-pong, 4 frames of 16 words, stride 0x100, core done 200 cycles after start → frame 2 loads to 0x100..0x10F during decode of frame 1. core_src_addr_o sequence is 0, 0x100, 0, 0x100. s_ready_o drops while both banks are full.
- Address wrap: base 0xFF8, frame_words 16 → writes to 0xFF8..0xFFF then 0x000..0x007.
- Watchdog: timeout_i=100, core never returns done → done_o and timeout_err_o=1 at exactly 100 cycles after start, busy_o=0. A new start_i clears timeout_err_o.
- Backpressure/robustness: random s_valid_i gaps, start_i pulsed again while busy (ignored), rst_sync_i asserted mid-WAIT → all outputs at reset values next cycle. A following run with frame_count=2 completes normally.

Source files
------------

// File: rtl/viterbi_frame_sequencer_if.sv
// Softbit stream bundle between an upstream source and the frame sequencer.
// Signals: s_valid_i, s_data_i (source->sequencer), s_ready_o (sequencer->source).
interface viterbi_frame_sequencer_if #(
    parameter int SOFT_W = 24
);
    logic              s_valid_i;
    logic [SOFT_W-1:0] s_data_i;
    logic              s_ready_o;

    modport master (
        output s_valid_i,
        output s_data_i,
        input  s_ready_o
    );

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        output s_ready_o
    );
endinterface

// File: rtl/viterbi_frame_sequencer.sv
// Frame sequencer: loads softbit frames into the decoder input SRAM
// (optionally ping-pong banked), fires frame start and waits for done.
// Ports: clk_i/rst_sync_i; start_i + run config; s_if softbit stream;
// buf_* SRAM write port; core_* decoder handshake; busy/done/status.
module viterbi_frame_sequencer #(
    parameter int SOFT_W     = 24,
    parameter int SRC_ADDR_W = 12,
    parameter int LEN_W      = 12,
    parameter int NFRM_W     = 8,
    parameter int TMO_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_sync_i,
    input  logic                  start_i,
    input  logic [NFRM_W-1:0]     frame_count_i,
    input  logic [LEN_W-1:0]      frame_words_i,
    input  logic [SRC_ADDR_W-1:0] src_base_i,
    input  logic [SRC_ADDR_W-1:0] bank_stride_i,
    input  logic                  pingpong_i,
    input  logic [7:0]            gap_cycles_i,
    input  logic [TMO_W-1:0]      timeout_i,
    viterbi_frame_sequencer_if.slave s_if,
    output logic                  buf_wr_o,
    output logic [SRC_ADDR_W-1:0] buf_addr_o,
    output logic [SOFT_W-1:0]     buf_wdata_o,
    output logic                  core_frame_start_o,
    output logic [SRC_ADDR_W-1:0] core_src_addr_o,
    input  logic                  core_frame_done_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [NFRM_W-1:0]     frames_done_o,
    output logic                  timeout_err_o
);

    typedef enum logic [2:0] {
        C_IDLE,
        C_ARM,
        C_GAP,
        C_START,
        C_WAIT
    } state_t;

    state_t                state_q, state_d;

    logic [NFRM_W-1:0]     fc_q, fc_d;
    logic [LEN_W-1:0]      fw_q, fw_d;
    logic [SRC_ADDR_W-1:0] base_q, base_d;
    logic [SRC_ADDR_W-1:0] stride_q, stride_d;
    logic                  pp_q, pp_d;
    logic [7:0]            gap_q, gap_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    logic [1:0]            full_q, full_d;
    logic                  wb_q, wb_d;
    logic                  rb_q, rb_d;
    logic [LEN_W-1:0]      wi_q, wi_d;
    logic [NFRM_W-1:0]     loaded_q, loaded_d;
    logic [NFRM_W-1:0]     fdone_q, fdone_d;
    logic [7:0]            gcnt_q, gcnt_d;
    logic [TMO_W-1:0]      wd_q, wd_d;
    logic                  done_q, done_d;
    logic                  terr_q, terr_d;
    logic [SRC_ADDR_W-1:0] caddr_q, caddr_d;
    logic                  bwr_q, bwr_d;
    logic [SRC_ADDR_W-1:0] baddr_q, baddr_d;
    logic [SOFT_W-1:0]     bdata_q, bdata_d;

    logic                  ready;
    logic                  accept;
    logic [SRC_ADDR_W-1:0] addr_wb;
    logic [SRC_ADDR_W-1:0] addr_rb;
    logic [TMO_W-1:0]      wd_inc;

    assign addr_wb = base_q + (wb_q ? stride_q : '0);
    assign addr_rb = base_q + (rb_q ? stride_q : '0);
    assign wd_inc  = wd_q + 1'b1;

    assign ready  = (state_q != C_IDLE) && !full_q[wb_q] && (loaded_q < fc_q);
    assign accept = ready && s_if.s_valid_i;

    assign s_if.s_ready_o     = ready;
    assign buf_wr_o           = bwr_q;
    assign buf_addr_o         = baddr_q;
    assign buf_wdata_o        = bdata_q;
    assign core_frame_start_o = (state_q == C_START);
    assign core_src_addr_o    = caddr_q;
    assign busy_o             = (state_q != C_IDLE);
    assign done_o             = done_q;
    assign frames_done_o      = fdone_q;
    assign timeout_err_o      = terr_q;

    always_comb begin
        state_d  = state_q;
        fc_d     = fc_q;
        fw_d     = fw_q;
        base_d   = base_q;
        stride_d = stride_q;
        pp_d     = pp_q;
        gap_d    = gap_q;
        tmo_d    = tmo_q;
        full_d   = full_q;
        wb_d     = wb_q;
        rb_d     = rb_q;
        wi_d     = wi_q;
        loaded_d = loaded_q;
        fdone_d  = fdone_q;
        gcnt_d   = gcnt_q;
        wd_d     = wd_q;
        done_d   = 1'b0;
        terr_d   = terr_q;
        caddr_d  = caddr_q;
        bwr_d    = accept;
        baddr_d  = baddr_q;
        bdata_d  = bdata_q;

        // Loader runs independently of the controller state.
        if (accept) begin
            baddr_d = addr_wb + SRC_ADDR_W'(wi_q);
            bdata_d = s_if.s_data_i;
            if (wi_q == fw_q - 1'b1) begin
                wi_d         = '0;
                full_d[wb_q] = 1'b1;
                loaded_d     = loaded_q + 1'b1;
                if (pp_q) begin
                    wb_d = ~wb_q;
                end
            end else begin
                wi_d = wi_q + 1'b1;
            end
        end

        // Controller updates come after the loader so an abort
        // clear of full[] wins over a same-cycle fill.
        unique case (state_q)
            C_IDLE: begin
                if (start_i) begin
                    fc_d     = frame_count_i;
                    fw_d     = (frame_words_i == '0) ? LEN_W'(1) : frame_words_i;
                    base_d   = src_base_i;
                    stride_d = bank_stride_i;
                    pp_d     = pingpong_i;
                    gap_d    = gap_cycles_i;
                    tmo_d    = timeout_i;
                    full_d   = '0;
                    wb_d     = 1'b0;
                    rb_d     = 1'b0;
                    wi_d     = '0;
                    loaded_d = '0;
                    fdone_d  = '0;
                    terr_d   = 1'b0;
                    if (frame_count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = C_ARM;
                    end
                end
            end
            C_ARM: begin
                if (full_q[rb_q]) begin
                    gcnt_d  = gap_q;
                    state_d = C_GAP;
                end
            end
            C_GAP: begin
                if (gcnt_q == '0) begin
                    caddr_d = addr_rb;
                    state_d = C_START;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            C_START: begin
                // The start cycle is the first watchdog cycle, so the
                // abort done_o lands timeout_i cycles after the pulse.
                wd_d    = TMO_W'(1);
                state_d = C_WAIT;
            end
            C_WAIT: begin
                if (core_frame_done_i) begin
                    full_d[rb_q] = 1'b0;
                    fdone_d      = fdone_q + 1'b1;
                    if (pp_q) begin
                        rb_d = ~rb_q;
                    end
                    if (fdone_q + 1'b1 == fc_q) begin
                        done_d  = 1'b1;
                        state_d = C_IDLE;
                    end else begin
                        state_d = C_ARM;
                    end
                end else if (tmo_q != '0 && wd_inc >= tmo_q) begin
                    terr_d  = 1'b1;
                    done_d  = 1'b1;
                    full_d  = '0;
                    state_d = C_IDLE;
                end else begin
                    wd_d = wd_inc;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            state_q  <= C_IDLE;
            fc_q     <= '0;
            fw_q     <= '0;
            base_q   <= '0;
            stride_q <= '0;
            pp_q     <= 1'b0;
            gap_q    <= '0;
            tmo_q    <= '0;
            full_q   <= '0;
            wb_q     <= 1'b0;
            rb_q     <= 1'b0;
            wi_q     <= '0;
            loaded_q <= '0;
            fdone_q  <= '0;
            gcnt_q   <= '0;
            wd_q     <= '0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
            caddr_q  <= '0;
            bwr_q    <= 1'b0;
            baddr_q  <= '0;
            bdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            fc_q     <= fc_d;
            fw_q     <= fw_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            pp_q     <= pp_d;
            gap_q    <= gap_d;
            tmo_q    <= tmo_d;
            full_q   <= full_d;
            wb_q     <= wb_d;
            rb_q     <= rb_d;
            wi_q     <= wi_d;
            loaded_q <= loaded_d;
            fdone_q  <= fdone_d;
            gcnt_q   <= gcnt_d;
            wd_q     <= wd_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
            caddr_q  <= caddr_d;
            bwr_q    <= bwr_d;
            baddr_q  <= baddr_d;
            bdata_q  <= bdata_d;
        end
    end

endmodule

// File: tb/tb_viterbi_frame_sequencer.sv
// Self-checking bench for viterbi_frame_sequencer: random stream gaps,
// latencies and configs against a frame/bank level reference model.
module tb_viterbi_frame_sequencer;
    localparam int SOFT_W     = 24;
    localparam int SRC_ADDR_W = 12;
    localparam int LEN_W      = 12;
    localparam int NFRM_W     = 8;
    localparam int TMO_W      = 16;
    localparam int AMOD       = 1 << SRC_ADDR_W;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [NFRM_W-1:0]     frame_count = '0;
    logic [LEN_W-1:0]      frame_words = '0;
    logic [SRC_ADDR_W-1:0] src_base = '0;
    logic [SRC_ADDR_W-1:0] bank_stride = '0;
    logic                  pingpong = 1'b0;
    logic [7:0]            gap_cycles = '0;
    logic [TMO_W-1:0]      timeout = '0;
    logic                  buf_wr;
    logic [SRC_ADDR_W-1:0] buf_addr;
    logic [SOFT_W-1:0]     buf_wdata;
    logic                  core_start;
    logic [SRC_ADDR_W-1:0] core_addr;
    logic                  core_done = 1'b0;
    logic                  busy;
    logic                  done;
    logic [NFRM_W-1:0]     frames_done;
    logic                  terr;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    viterbi_frame_sequencer_if #(.SOFT_W(SOFT_W)) s_if ();

    viterbi_frame_sequencer #(
        .SOFT_W(SOFT_W), .SRC_ADDR_W(SRC_ADDR_W), .LEN_W(LEN_W),
        .NFRM_W(NFRM_W), .TMO_W(TMO_W)
    ) dut (
        .clk_i              (clk),
        .rst_sync_i         (rst),
        .start_i            (start),
        .frame_count_i      (frame_count),
        .frame_words_i      (frame_words),
        .src_base_i         (src_base),
        .bank_stride_i      (bank_stride),
        .pingpong_i         (pingpong),
        .gap_cycles_i       (gap_cycles),
        .timeout_i          (timeout),
        .s_if               (s_if.slave),
        .buf_wr_o           (buf_wr),
        .buf_addr_o         (buf_addr),
        .buf_wdata_o        (buf_wdata),
        .core_frame_start_o (core_start),
        .core_src_addr_o    (core_addr),
        .core_frame_done_i  (core_done),
        .busy_o             (busy),
        .done_o             (done),
        .frames_done_o      (frames_done),
        .timeout_err_o      (terr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, s_if.s_ready_o, 0);
        check({tag, "_bwr"}, buf_wr, 0);
        check({tag, "_baddr"}, buf_addr, 0);
        check({tag, "_bdata"}, buf_wdata, 0);
        check({tag, "_cstart"}, core_start, 0);
        check({tag, "_caddr"}, core_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fdone"}, frames_done, 0);
        check({tag, "_terr"}, terr, 0);
    endtask

    // One run. Model: frame k lands in bank (pp ? k%2 : 0), word i at
    // (base + bank*stride + i) mod 2^12; frames decode in load order;
    // a bank is busy from its last write until the core's done.
    task automatic run(input int fc, input int fw_in, input int base,
                       input int stride, input bit pp, input int gap,
                       input int lat, input int vpct, input int tmo,
                       input bit poke, input bit rst_mid);
        int fw, cap, nw, nacc, nstart, ndone, ndone_o, s_cyc, limit;
        int k, bank, outst, full2, exp_last;
        bit fin, dprev, exp_rdy;
        int last_acc[$];
        logic [SOFT_W-1:0] dq[$];
        logic [SOFT_W-1:0] d;
        fw = (fw_in == 0) ? 1 : fw_in;
        cap = pp ? 2 : 1;
        nw = 0; nacc = 0; nstart = 0; ndone = 0; ndone_o = 0;
        s_cyc = -1; fin = 0; dprev = 0; full2 = 0;
        frame_count = NFRM_W'(fc);
        frame_words = LEN_W'(fw_in);
        src_base = SRC_ADDR_W'(base);
        bank_stride = SRC_ADDR_W'(stride);
        pingpong = pp;
        gap_cycles = 8'(gap);
        timeout = TMO_W'(tmo);
        start = 1'b1;
        step();
        start = 1'b0;
        // Config is latched at start; scramble the inputs afterwards.
        frame_count = NFRM_W'($urandom);
        frame_words = LEN_W'($urandom);
        src_base = SRC_ADDR_W'($urandom);
        bank_stride = SRC_ADDR_W'($urandom);
        pingpong = 1'($urandom);
        gap_cycles = 8'($urandom);
        timeout = TMO_W'($urandom_range(1, 3));
        check("busy_rise", busy, fc != 0);
        check("done_fc0", done, fc == 0);
        check("terr_clr", terr, 0);
        if (fc == 0) begin
            step();
            check("fc0_idle", busy, 0);
            return;
        end
        limit = cyc + 20000;
        while (!fin) begin
            if (buf_wr) begin
                k = nw / fw;
                bank = (pp && (k % 2 == 1)) ? 1 : 0;
                d = dq.pop_front();
                check("wr_addr", buf_addr,
                      (base + bank * stride + (nw % fw)) % AMOD);
                check("wr_data", buf_wdata, d);
                nw++;
            end
            if (core_start) begin
                bank = (pp && (nstart % 2 == 1)) ? 1 : 0;
                check("src_addr", core_addr, (base + bank * stride) % AMOD);
                if (!pp) begin
                    exp_last = (last_acc.size() > nstart) ? last_acc[nstart] : -100;
                    check("start_lat", cyc, exp_last + 3 + gap);
                end
                s_cyc = cyc;
                nstart++;
            end
            if (done) ndone_o++;
            if (dprev) begin
                check("frames_done", frames_done, ndone);
                if (ndone == fc) begin
                    check("run_done", done, 1);
                    check("busy_fall", busy, 0);
                    fin = 1;
                end
            end
            if (!fin && tmo != 0 && s_cyc >= 0 && cyc == s_cyc + tmo) begin
                check("wd_done", done, 1);
                check("wd_terr", terr, 1);
                check("wd_busy", busy, 0);
                fin = 1;
            end
            if (!fin && rst_mid && s_cyc >= 0 && cyc == s_cyc + 5) begin
                s_if.s_valid_i = 1'b0;
                core_done = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_reset_outputs("rst_mid");
                fin = 1;
            end
            if (!fin) begin
                outst = nw / fw - ndone;
                if (outst == 2) full2++;
                exp_rdy = (nw / fw < fc) && (outst < cap);
                check("ready", s_if.s_ready_o, exp_rdy);
            end
            if (!fin && cyc > limit) begin
                check("cycle_budget", 0, 1);
                fin = 1;
            end
            if (!fin) begin
                s_if.s_valid_i = ($urandom_range(99) < vpct);
                s_if.s_data_i = SOFT_W'($urandom);
                core_done = (lat > 0 && s_cyc >= 0 && cyc == s_cyc + lat);
                start = poke && (nw == 2 || nw == 5);
                dprev = core_done;
                if (core_done) ndone++;
                @(negedge clk);
                if (s_if.s_valid_i && s_if.s_ready_o) begin
                    dq.push_back(s_if.s_data_i);
                    nacc++;
                    if (nacc % fw == 0) last_acc.push_back(cyc);
                end
                step();
            end
        end
        s_if.s_valid_i = 1'b0;
        core_done = 1'b0;
        start = 1'b0;
        if (tmo == 0 && !rst_mid) begin
            check("write_count", nw, fc * fw);
            check("done_pulses", ndone_o, 1);
            check("data_left", dq.size(), 0);
        end
        if (pp && lat > 100) check("both_full_seen", full2 > 0, 1);
        step();
        step();
        if (tmo != 0) check("terr_sticky", terr, 1);
        check("idle_done", done, 0);
    endtask

    initial begin
        s_if.s_valid_i = 1'b0;
        s_if.s_data_i = '0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
        // single frame, 152 words, gap 0
        run(1, 'h98, 0, 0, 0, 0, 50, 100, 0, 0, 0);
        // ping-pong 4 x 16, stride 0x100, slow core
        run(4, 16, 0, 'h100, 1, 0, 200, 100, 0, 0, 0);
        // address wrap
        run(1, 16, 'hFF8, 0, 0, 0, 20, 100, 0, 0, 0);
        // watchdog: core never returns
        run(3, 8, 'h40, 0, 0, 2, 0, 100, 100, 0, 0);
        // zero frames
        run(0, 4, 0, 0, 0, 0, 5, 100, 0, 0, 0);
        // frame_words 0 means one word, with restart pokes
        run(2, 0, 'h10, 5, 1, 1, 7, 60, 0, 1, 0);
        for (int r = 0; r < 6; r++) begin
            run($urandom_range(1, 5), $urandom_range(0, 40),
                $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
                1'($urandom), $urandom_range(0, 5), $urandom_range(1, 60),
                $urandom_range(30, 100), 0, 1'($urandom), 0);
        end
        // reset during WAIT, then a clean two-frame run
        run(3, 12, 0, 'h80, 1, 0, 40, 50, 0, 0, 1);
        run(2, 10, 'h20, 'h200, 0, 3, 15, 70, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
